sar_ctrl: RTL and testbench

Synthesizable successive-approximation controller that drives the comparator's reference side and consumes its decision. It is the stimulus end of the comparator interface: it produces the trial code for n_i and reads the digitized c_o. In the RNM bench, a DAC model converts dac_code_o to real n_i = code*VREF/2**WIDTH, and c_o is sliced to cmp_i = (c_o > 0.5). The block runs one binary search per start_i pulse and returns the code.

---
 rtl/sar_ctrl_pkg.sv | 17 +
 rtl/sar_cmp_sync.sv | 25 ++
 rtl/sar_ctrl.sv | 135 +++++++++++++
 tb/tb_sar_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sar_ctrl_pkg.sv
// Shared types and defaults for the SAR controller.
// State encoding, default sizing and synchronizer depth.
package sar_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONVERT,
    DONE
  } sar_state_e;

  localparam int SAR_WIDTH         = 8;
  localparam int SAR_SAMPLE_CYCLES = 2;
  localparam int SAR_SETTLE_CYCLES = 2;
  localparam int SYNC_STAGES       = 2;

endpackage

// File: rtl/sar_cmp_sync.sv
// Multi-flop synchronizer for the comparator decision.
// Depth comes from SYNC_STAGES; resets to 0.
module sar_cmp_sync
  import sar_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff;

  // shift the raw decision through the flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[SYNC_STAGES-2:0], d};
    end
  end

  assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/sar_ctrl.sv
// Successive-approximation controller: one binary search per start.
// SAR_CTRL_CMP_SYNC_EN adds a cmp_i synchronizer and longer bit phases.
module sar_ctrl
  import sar_ctrl_pkg::*;
#(
  parameter int WIDTH         = SAR_WIDTH,
  parameter int SAMPLE_CYCLES = SAR_SAMPLE_CYCLES,
  parameter int SETTLE_CYCLES = SAR_SETTLE_CYCLES
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             cmp_i,
  output logic             sample_o,
  output logic [WIDTH-1:0] dac_code_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] data_o
);

  logic cmp;

`ifdef SAR_CTRL_CMP_SYNC_EN
  localparam int PHASE = SETTLE_CYCLES + SYNC_STAGES;

  sar_cmp_sync u_sync (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .d     (cmp_i),
    .q     (cmp)
  );
`else
  localparam int PHASE = SETTLE_CYCLES;

  assign cmp = cmp_i;
`endif

  localparam int MAXC = (SAMPLE_CYCLES > PHASE) ?
                        SAMPLE_CYCLES : PHASE;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(WIDTH);

  localparam logic [WIDTH-1:0] LSB =
    {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB =
    {1'b1, {(WIDTH-1){1'b0}}};

  sar_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] code_q, code_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] trial_bit;
  logic [WIDTH-1:0] kept;

  // state and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      code_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      data_q  <= data_d;
    end
  end

  // next state, bit trial update and status outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    code_d    = code_q;
    data_d    = data_q;
    sample_o  = 1'b0;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    trial_bit = LSB << idx_q;
    kept      = cmp ? code_q : (code_q & ~trial_bit);

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SAMPLE;
          cnt_d   = CW'(SAMPLE_CYCLES - 1);
          code_d  = '0;
        end
      end
      SAMPLE: begin
        sample_o = 1'b1;
        busy_o   = 1'b1;
        if (cnt_q == '0) begin
          state_d = CONVERT;
          idx_d   = IW'(WIDTH - 1);
          code_d  = MSB;
          cnt_d   = CW'(PHASE - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CONVERT: begin
        busy_o = 1'b1;
        if (cnt_q == '0) begin
          if (idx_q != '0) begin
            idx_d  = idx_q - 1'b1;
            code_d = kept | (trial_bit >> 1);
            cnt_d  = CW'(PHASE - 1);
          end else begin
            code_d  = kept;
            data_d  = kept;
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign dac_code_o = code_q;
  assign data_o     = data_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// Directed bench for sar_ctrl with an integer comparator model.
// Comparator: cmp_i = p*256 > code (p in thousandths of VREF).
module tb_sar_ctrl;

`ifdef SAR_CTRL_CMP_SYNC_EN
  localparam int LAT = 35;
`else
  localparam int LAT = 19;
`endif

  logic       clk_i   = 1'b0;
  logic       rst_ni  = 1'b0;
  logic       start_i = 1'b0;
  logic       cmp_i;
  logic       sample_o;
  logic [7:0] dac_code_o;
  logic       busy_o;
  logic       done_o;
  logic [7:0] data_o;

  int p_milli = 0;
  int checks = 0;
  int failures = 0;
  logic [7:0] trials[$];

  always #5 clk_i = ~clk_i;

  assign cmp_i = (p_milli * 256) > (int'(dac_code_o) * 1000);

  sar_ctrl dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .cmp_i      (cmp_i),
    .sample_o   (sample_o),
    .dac_code_o (dac_code_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .data_o     (data_o)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_conv(input int pm,
                          input logic [7:0] exp,
                          input string tag);
    int sc;
    int dc;
    logic busy_at_done;
    logic [7:0] last;
    sc = 0;
    dc = 0;
    busy_at_done = 1'b1;
    last = 8'h00;
    trials.delete();
    p_milli = pm;
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    for (int k = 1; k <= LAT + 20; k++) begin
      @(negedge clk_i);
      if (sample_o) sc++;
      if (busy_o && !sample_o && dac_code_o != last) begin
        trials.push_back(dac_code_o);
        last = dac_code_o;
      end
      if (done_o) begin
        dc = k;
        busy_at_done = busy_o;
        break;
      end
    end
    check({tag, "_lat"}, dc, LAT);
    check({tag, "_data"}, data_o, exp);
    check({tag, "_sample"}, sc, 2);
    check({tag, "_busy_done"}, busy_at_done, 0);
    @(negedge clk_i);
  endtask

  initial begin
    logic [7:0] exp_tr[8];
    int dones;
    int first;
    int second;
    int busy_after;
    exp_tr = '{8'h80, 8'h40, 8'h60, 8'h50,
               8'h48, 8'h4C, 8'h4E, 8'h4D};

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_sample", sample_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_dac", dac_code_o, 0);
    check("rst_data", data_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    run_conv(502, 8'h80, "p502");

    run_conv(300, 8'h4C, "p300");
    check("p300_ntrials", trials.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < trials.size())
        check($sformatf("p300_trial%0d", i), trials[i], exp_tr[i]);
    end
    check("p300_dac_hold", dac_code_o, 8'h4C);

    run_conv(0, 8'h00, "p000");
    run_conv(1000, 8'hFF, "p1000");
    run_conv(500, 8'h7F, "p500_equal");

    // start held high continuously
    p_milli = 300;
    dones = 0;
    first = 0;
    second = 0;
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    for (int k = 1; k <= 3 * LAT; k++) begin
      @(negedge clk_i);
      if (done_o) begin
        dones++;
        if (dones == 1) first = k;
        if (dones == 2) begin
          second = k;
          start_i = 1'b0;
          break;
        end
      end
    end
    start_i = 1'b0;
    check("b2b_dones", dones, 2);
    check("b2b_first", first, LAT);
    check("b2b_spacing", second - first, LAT + 1);
    check("b2b_data", data_o, 8'h4C);
    @(negedge clk_i);
    @(negedge clk_i);

    // starts during busy and done are ignored
    p_milli = 1000;
    dones = 0;
    first = 0;
    busy_after = 0;
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    for (int k = 1; k <= LAT + 30; k++) begin
      @(negedge clk_i);
      start_i = (k == 3 || k == 10 || k == LAT);
      if (done_o) begin
        dones++;
        if (dones == 1) first = k;
      end
      if (k > LAT && busy_o) busy_after++;
    end
    start_i = 1'b0;
    check("ign_dones", dones, 1);
    check("ign_first", first, LAT);
    check("ign_busy_after", busy_after, 0);
    check("ign_data", data_o, 8'hFF);

    // asynchronous reset in cycle 7 of a conversion
    p_milli = 502;
    dones = 0;
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    for (int k = 1; k <= 7; k++) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_sample", sample_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_done", done_o, 0);
    check("arst_dac", dac_code_o, 0);
    check("arst_data", data_o, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    busy_after = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk_i);
      if (done_o) dones++;
      if (busy_o) busy_after++;
    end
    check("arst_no_done", dones, 0);
    check("arst_idle", busy_after, 0);

    run_conv(300, 8'h4C, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
